// File: rtl/priority_arbiter.sv
// Eight-requester arbiter with fixed-priority or round-robin selection and a
// bounded hold time per grant; every output comes straight from a flop.
module priority_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       rr_mode,
    output logic [7:0] grant,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] grant_q;
    logic [2:0] gnt_id_q;
    logic       gnt_valid_q;
    logic       timeout_q;
    logic [7:0] hold_q;
    logic [2:0] last_id_q;

    logic [2:0] winner_d;
    logic       owner_req_s;
    logic       expired_s;
    logic       release_s;
    logic       forced_s;

    // Highest set index wins; later iterations overwrite earlier ones.
    function automatic logic [2:0] fixed_pick(input logic [7:0] r);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                id = i[2:0];
            end
        end
        return id;
    endfunction

    // Search downward from last-1 with wrap; the smallest distance wins, so
    // the loop runs from the farthest candidate to the nearest.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] id;
        logic [2:0] cand;
        id = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = last - 3'd1 - k[2:0];
            if (r[cand]) begin
                id = cand;
            end
        end
        return id;
    endfunction

    assign owner_req_s = req[gnt_id_q];
    assign expired_s   = (hold_q == HOLD_LAST);
    assign release_s   = done | ~owner_req_s | expired_s;
    assign forced_s    = expired_s & ~done & owner_req_s;

    // Winner selection for the next grant, policy taken from rr_mode.
    always_comb begin
        winner_d = 3'd0;
        if (rr_mode) begin
            winner_d = rr_pick(req, last_id_q);
        end else begin
            winner_d = fixed_pick(req);
        end
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= 8'h00;
            last_id_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    hold_q    <= 8'h00;
                    if (req != 8'h00) begin
                        state_q     <= BUSY;
                        grant_q     <= 8'b0000_0001 << winner_d;
                        gnt_id_q    <= winner_d;
                        gnt_valid_q <= 1'b1;
                        last_id_q   <= winner_d;
                    end else begin
                        state_q     <= IDLE;
                        grant_q     <= 8'h00;
                        gnt_id_q    <= 3'd0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_s) begin
                        state_q     <= IDLE;
                        grant_q     <= 8'h00;
                        gnt_id_q    <= 3'd0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= forced_s;
                        hold_q      <= 8'h00;
                    end else begin
                        state_q   <= BUSY;
                        timeout_q <= 1'b0;
                        // Saturate rather than wrap, even for out-of-range TIMEOUT.
                        if (hold_q != 8'hFF) begin
                            hold_q <= hold_q + 8'd1;
                        end else begin
                            hold_q <= hold_q;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_q     <= 8'h00;
                    gnt_id_q    <= 3'd0;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    hold_q      <= 8'h00;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter: a behavioural model queues expected
// outputs per driven cycle, which are popped and compared after the edge.
module tb_priority_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       rr_mode;
    logic [7:0] grant;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    priority_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .rr_mode   (rr_mode),
        .grant     (grant),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       t;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model state
    logic       m_busy = 1'b0;
    logic [2:0] m_id   = 3'd0;
    logic [2:0] m_last = 3'd0;
    int         m_hold = 0;
    logic       m_to   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_pick(input logic [7:0] r, input logic rr, input logic [2:0] last);
        int idx;
        if (!rr) begin
            for (int i = 7; i >= 0; i--) begin
                if (r[i]) return i[2:0];
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = (int'(last) - k + 16) % 8;
                if (r[idx]) return idx[2:0];
            end
        end
        return 3'd0;
    endfunction

    task automatic model(input logic rn, input logic [7:0] r, input logic d, input logic m);
        logic       expd;
        logic [2:0] w;
        if (!rn) begin
            m_busy = 1'b0; m_id = 3'd0; m_last = 3'd0; m_hold = 0; m_to = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            if (r != 8'h00) begin
                w = m_pick(r, m, m_last);
                m_busy = 1'b1; m_id = w; m_last = w; m_hold = 0;
            end
        end else begin
            expd = (m_hold == TO - 1);
            if (d || !r[m_id] || expd) begin
                m_to   = expd && !d && r[m_id];
                m_busy = 1'b0;
                m_id   = 3'd0;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic rn, input logic [7:0] r, input logic d, input logic m);
        exp_t e;
        @(negedge clk);
        rst_n = rn; req = r; done = d; rr_mode = m;
        model(rn, r, d, m);
        e.g  = m_busy ? (8'b0000_0001 << m_id) : 8'h00;
        e.id = m_busy ? m_id : 3'd0;
        e.v  = m_busy;
        e.t  = m_to;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("gnt_id", 32'(gnt_id), 32'(e.id));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
        chk("timeout", 32'(timeout), 32'(e.t));
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; done = 1'b0; rr_mode = 1'b0;

        // reset state
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'hFF, 1'b1, 1'b1);
        chk("rst_outs", 32'({grant, gnt_id, gnt_valid, timeout}), 32'd0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        chk("idle_empty", 32'(gnt_valid), 32'd0);

        // fixed priority: highest index wins, regranted after one-cycle gap
        step(1'b1, 8'b0010_0101, 1'b0, 1'b0);
        chk("fix_grant", 32'(grant), 32'h20);
        chk("fix_id", 32'(gnt_id), 32'd5);
        step(1'b1, 8'b0010_0101, 1'b0, 1'b0);
        step(1'b1, 8'b0010_0101, 1'b1, 1'b0);
        chk("fix_gap", 32'(grant), 32'h00);
        step(1'b1, 8'b0010_0101, 1'b0, 1'b0);
        chk("fix_regrant", 32'(grant), 32'h20);
        step(1'b1, 8'b0010_0101, 1'b1, 1'b0);

        // round-robin from reset: 7,6,...,0,7
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            logic [2:0] ex;
            ex = 3'(7 - k);
            step(1'b1, 8'hFF, 1'b0, 1'b1);
            chk("rr_seq", 32'({gnt_valid, gnt_id}), 32'({1'b1, ex}));
            step(1'b1, 8'hFF, 1'b1, 1'b1);
            chk("rr_gap", 32'(gnt_valid), 32'd0);
        end

        // timeout: 4 busy cycles, a pulse, then regrant
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < TO; k++) begin
            step(1'b1, 8'h01, 1'b0, 1'b0);
            chk("to_valid", 32'(gnt_valid), 32'd1);
        end
        step(1'b1, 8'h01, 1'b0, 1'b0);
        chk("to_pulse", 32'({gnt_valid, timeout}), 32'b01);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        chk("to_regrant", 32'({gnt_valid, gnt_id, timeout}), 32'b1_000_0);

        // done coinciding with expiry is a normal release
        for (int k = 0; k < TO - 1; k++) step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        chk("coinc", 32'({gnt_valid, timeout}), 32'b00);

        // owner drops its request mid-grant
        step(1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("drop", 32'({grant, timeout}), 32'd0);

        // reset mid-grant, then round-robin starts again at 7
        step(1'b1, 8'h08, 1'b0, 1'b1);
        chk("pre_rst_id", 32'(gnt_id), 32'd3);
        step(1'b0, 8'h08, 1'b0, 1'b1);
        chk("mid_rst", 32'({grant, gnt_id, gnt_valid, timeout}), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("post_rst_rr", 32'(gnt_id), 32'd7);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic rn;
            rn = ($urandom_range(0, 49) != 0);
            step(rn, 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
